// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, bit positions and helpers for the multi-channel APB timer
package apb_timer_pkg;

    // Per-channel register offsets within the 4-byte channel window
    localparam logic [1:0] OFF_TDR  = 2'd0;
    localparam logic [1:0] OFF_TCR  = 2'd1;
    localparam logic [1:0] OFF_TSR  = 2'd2;
    localparam logic [1:0] OFF_TCNT = 2'd3;

    // TCR bit positions
    localparam int TCR_LOAD   = 7;
    localparam int TCR_IE     = 6;
    localparam int TCR_DIR    = 5;
    localparam int TCR_EN     = 4;
    localparam int TCR_AR     = 3;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;

    // TSR bit positions
    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    // Bit 2 of TCR is reserved and always reads back as zero
    localparam logic [7:0] TCR_WMASK = 8'hFB;

    // Clock-select encoding
    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    // Pick the prescaler tick that matches a channel's clock select
    function automatic logic tick_sel(input logic [3:0] ticks, input logic [1:0] cks);
        return ticks[cks];
    endfunction

endpackage

// File: rtl/apb_timer_channel.sv
// rtl/apb_timer_channel.sv - one timer channel: TDR/TCR/TSR/TCNT, count events and irq
module apb_timer_channel
    import apb_timer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        rd_off,
    input  logic [3:0]        ticks,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam logic [DATA_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] tdr;
    logic [DATA_W-1:0] tcnt;
    logic [7:0]        tcr;
    logic [1:0]        tsr;
    logic              tick;
    logic              ovf_set;
    logic              udf_set;
    logic [1:0]        tsr_clr;

    // A channel only advances on its own tick while enabled and not being loaded
    assign tick    = tcr[TCR_EN] & ~tcr[TCR_LOAD] & tick_sel(ticks, tcr[TCR_CKS_HI:TCR_CKS_LO]);
    assign ovf_set = tick & ~tcr[TCR_DIR] & (tcnt == CNT_MAX);
    assign udf_set = tick &  tcr[TCR_DIR] & (tcnt == '0);
    assign tsr_clr = (wr_en && wr_off == OFF_TSR) ? wdata[1:0] : 2'b00;

    // Software-writable configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tdr <= '0;
            tcr <= '0;
        end else if (wr_en) begin
            if (wr_off == OFF_TDR) tdr <= wdata;
            if (wr_off == OFF_TCR) tcr <= wdata[7:0] & TCR_WMASK;
        end
    end

    // Live counter: LOAD forces the reload value, otherwise step on the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tcr[TCR_LOAD]) begin
            tcnt <= tdr;
        end else if (tick) begin
            if (tcr[TCR_DIR]) begin
                if (tcnt == '0) tcnt <= tcr[TCR_AR] ? tdr : CNT_MAX;
                else            tcnt <= tcnt - 1'b1;
            end else begin
                if (tcnt == CNT_MAX) tcnt <= tcr[TCR_AR] ? tdr : '0;
                else                 tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Sticky status flags; a hardware set beats a same-cycle write-one-to-clear
    always_ff @(posedge clk) begin
        if (rst) tsr <= 2'b00;
        else     tsr <= (tsr & ~tsr_clr) | {udf_set, ovf_set};
    end

    // Registered level interrupt, one cycle behind the flags
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= tcr[TCR_IE] & (|tsr);
    end

    // Register read-back for the selected offset
    always_comb begin
        rdata = '0;
        case (rd_off)
            OFF_TDR:  rdata = tdr;
            OFF_TCR:  rdata = DATA_W'(tcr);
            OFF_TSR:  rdata = DATA_W'(tsr);
            default:  rdata = tcnt;
        endcase
    end

endmodule

// File: rtl/apb_timer_multi.sv
// rtl/apb_timer_multi.sv - multi-channel APB timer: bus decode, shared prescaler, read mux
module apb_timer_multi
    import apb_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);

    localparam int                CH_AW      = ADDR_W - 2;
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(4 * NUM_CH);

    logic              access;
    logic              err;
    logic              wr_ok;
    logic              rd_ok;
    logic [3:0]        psc;
    logic [3:0]        ticks;
    logic [DATA_W-1:0] ch_rdata [NUM_CH];

    // Zero-wait-state slave: errors cover unmapped addresses and TCNT writes
    assign access  = psel & penable;
    assign err     = access & (({1'b0, paddr} >= ADDR_LIMIT) | (pwrite & (paddr[1:0] == OFF_TCNT)));
    assign wr_ok   = access & pwrite & ~err;
    assign rd_ok   = access & ~pwrite & ~err;
    assign pready  = access;
    assign pslverr = err;

    // Shared free-running prescaler
    always_ff @(posedge pclk) begin
        if (preset) psc <= 4'd0;
        else        psc <= psc + 4'd1;
    end

    // tick_k fires when the low k+1 prescaler bits are all ones
    assign ticks = {&psc[3:0], &psc[2:0], &psc[1:0], psc[0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        apb_timer_channel #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk    (pclk),
            .rst    (preset),
            .wr_en  (wr_ok && (paddr[ADDR_W-1:2] == CH_AW'(c))),
            .wr_off (paddr[1:0]),
            .wdata  (pwdata),
            .rd_off (paddr[1:0]),
            .ticks  (ticks),
            .rdata  (ch_rdata[c]),
            .irq    (irq[c])
        );
    end

    // Read mux: data only during a good read access phase
    always_comb begin
        prdata = '0;
        if (rd_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (paddr[ADDR_W-1:2] == CH_AW'(c)) prdata = ch_rdata[c];
            end
        end
    end

endmodule
